// File: rtl/sdf_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the radix-2^2 SDF FFT output.
// Optional overflow detection/drop logic enabled by defining SDF_REORDER_OVF_EN.
module sdf_bitrev_reorder #(
    parameter int N     = 64,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_in,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             enable_out,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
`ifdef SDF_REORDER_OVF_EN
    output logic             overflow,
`endif
    output logic             frame_last
);

    localparam int              LOGN     = $clog2(N);
    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

    typedef enum logic {
        IDLE,
        READ
    } rd_state_t;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = a[LOGN-1-i];
        end
        return r;
    endfunction

    logic [2*WIDTH-1:0] mem [2*N];

    logic [LOGN-1:0] wcnt;
    logic [LOGN-1:0] rcnt;
    logic [LOGN-1:0] rcnt_next;
    logic            wbank;
    logic            rbank;
    logic            rbank_next;
    logic [1:0]      full;
    logic [1:0]      full_set;
    logic [1:0]      full_clr;
    logic            wr_en;
    logic            wr_last;
    logic            rd_en;
    logic            rd_last;
    rd_state_t       state;
    rd_state_t       state_next;

    // A bank whose last read issues on this edge counts as free, so gapless
    // streaming can start the next frame into it without being flagged.
    always_comb begin
        rd_en    = (state == READ);
        rd_last  = rd_en && (rcnt == LAST_IDX);
        full_clr = rd_last ? (2'b01 << rbank) : 2'b00;
`ifdef SDF_REORDER_OVF_EN
        wr_en    = enable_in && !(full[wbank] && !full_clr[wbank]);
`else
        wr_en    = enable_in;
`endif
        wr_last  = wr_en && (wcnt == LAST_IDX);
        full_set = wr_last ? (2'b01 << wbank) : 2'b00;
    end

    // NOTE: every signal written in always_comb gets a default first;
    // a path that leaves one unassigned infers a latch.
    always_comb begin
        state_next = state;
        rcnt_next  = rcnt;
        rbank_next = rbank;
        case (state)
            IDLE: begin
                if (full[rbank]) begin
                    state_next = READ;
                    rcnt_next  = '0;
                end
            end
            READ: begin
                rcnt_next = rcnt + LOGN'(1);
                if (rd_last) begin
                    rbank_next = ~rbank;
                    if (full[~rbank] || full_set[~rbank]) begin
                        state_next = READ;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rcnt  <= '0;
            rbank <= 1'b0;
            wcnt  <= '0;
            wbank <= 1'b0;
            full  <= 2'b00;
        end else begin
            state <= state_next;
            rcnt  <= rcnt_next;
            rbank <= rbank_next;
            full  <= (full & ~full_clr) | full_set;
            if (wr_en) begin
                wcnt <= wcnt + LOGN'(1);
                if (wr_last) begin
                    wbank <= ~wbank;
                end
            end
        end
    end

    // NOTE: the sample RAM is deliberately not reset; the full flags gate
    // every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wbank, bitrev(wcnt)}] <= {in_re, in_im};
        end
    end

    // Output registers double as the RAM read register: data lands one cycle
    // after the read issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_out <= 1'b0;
            frame_last <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
        end else begin
            enable_out <= rd_en;
            frame_last <= rd_last;
            if (rd_en) begin
                {out_re, out_im} <= mem[{rbank, rcnt}];
            end
        end
    end

`ifdef SDF_REORDER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (enable_in && !wr_en) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Directed bench for sdf_bitrev_reorder: N=8 ordering/latency/reset cases and
// a 10-frame N=64 run against a bit-reversal reference.
module tb_sdf_bitrev_reorder;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         en8 = 1'b0,  en64 = 1'b0;
    logic [W-1:0] re8 = '0, im8 = '0, re64 = '0, im64 = '0;
    logic         eo8, fl8, eo64, fl64;
    logic [W-1:0] or8, oi8, or64, oi64;
`ifdef SDF_REORDER_OVF_EN
    logic         ovf8, ovf64;
`endif

    sdf_bitrev_reorder #(.N(8), .WIDTH(W)) dut8 (
        .clk(clk), .rst(rst), .enable_in(en8), .in_re(re8), .in_im(im8),
        .enable_out(eo8), .out_re(or8), .out_im(oi8),
`ifdef SDF_REORDER_OVF_EN
        .overflow(ovf8),
`endif
        .frame_last(fl8)
    );

    sdf_bitrev_reorder #(.N(64), .WIDTH(W)) dut64 (
        .clk(clk), .rst(rst), .enable_in(en64), .in_re(re64), .in_im(im64),
        .enable_out(eo64), .out_re(or64), .out_im(oi64),
`ifdef SDF_REORDER_OVF_EN
        .overflow(ovf64),
`endif
        .frame_last(fl64)
    );

    typedef struct {
        int           c;
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         last;
    } smp_t;

    smp_t q8[$];
    smp_t q64[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total = 0;

    logic [2:0] br8 [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    logic [W-1:0] dr [640];
    logic [W-1:0] di [640];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (eo8 === 1'b1)  q8.push_back('{cyc, or8, oi8, fl8});
        if (eo64 === 1'b1) q64.push_back('{cyc, or64, oi64, fl64});
    end

    function automatic logic [5:0] ref_bitrev6(input logic [5:0] a);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = a[5-i];
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        en8  = 1'b0;
        en64 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q8.delete();
        q64.delete();
    endtask

    task automatic drive8(input logic [W-1:0] base, input int nsamp, input bit gapped,
                          output int t_last);
        t_last = 0;
        for (int i = 0; i < nsamp; i++) begin
            @(negedge clk);
            en8 = 1'b1;
            re8 = base + W'(i);
            im8 = W'(0) - (base + W'(i));
            @(posedge clk);
            #1 t_last = cyc;
            if (gapped) begin
                @(negedge clk);
                en8 = 1'b0;
            end
        end
    endtask

    task automatic wait_q(input bit big, input int n, input int budget, input string name);
        int k = 0;
        while (((big ? q64.size() : q8.size()) < n) && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        total++;
        if ((big ? q64.size() : q8.size()) < n)
            $display("FAIL %s timeout: got %0d samples, need %0d", name,
                     big ? q64.size() : q8.size(), n);
        else
            pass_cnt++;
    endtask

    task automatic check_frame8(input int qidx, input logic [W-1:0] base, input int t_first,
                                input string name);
        smp_t s;
        logic [W-1:0] er, ei;
        for (int j = 0; j < 8; j++) begin
            er = base + W'(br8[j]);
            ei = W'(0) - er;
            total++;
            if (qidx + j >= q8.size()) begin
                $display("FAIL %s[%0d] missing sample", name, j);
            end else begin
                s = q8[qidx+j];
                if (s.c !== t_first + j || s.re !== er || s.im !== ei || s.last !== (j == 7))
                    $display("FAIL %s[%0d] got cyc=%0d re=%h im=%h last=%b exp cyc=%0d re=%h im=%h last=%b",
                             name, j, s.c, s.re, s.im, s.last, t_first + j, er, ei, (j == 7));
                else
                    pass_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (eo8 !== 1'b0) $display("FAIL rst_enable_out got %b exp 0", eo8); else pass_cnt++;
        total++; if (fl8 !== 1'b0) $display("FAIL rst_frame_last got %b exp 0", fl8); else pass_cnt++;
        total++; if (or8 !== 8'h00) $display("FAIL rst_out_re got %h exp 00", or8); else pass_cnt++;
        total++; if (oi8 !== 8'h00) $display("FAIL rst_out_im got %h exp 00", oi8); else pass_cnt++;
        total++; if (eo64 !== 1'b0) $display("FAIL rst_enable_out64 got %b exp 0", eo64); else pass_cnt++;
`ifdef SDF_REORDER_OVF_EN
        total++; if (ovf8 !== 1'b0) $display("FAIL rst_overflow got %b exp 0", ovf8); else pass_cnt++;
`endif
    endtask

    task automatic test_single();
        int t;
        do_reset();
        drive8(8'd0, 8, 1'b0, t);
        @(negedge clk) en8 = 1'b0;
        wait_q(1'b0, 8, 40, "single_wait");
        total++;
        if (q8.size() !== 8) $display("FAIL single_count got %0d exp 8", q8.size()); else pass_cnt++;
        check_frame8(0, 8'd0, t + 2, "single");
    endtask

    task automatic test_back_to_back();
        int t0, t1, t2;
        do_reset();
        drive8(8'd0, 8, 1'b0, t0);
        drive8(8'd8, 8, 1'b0, t1);
        drive8(8'd16, 8, 1'b0, t2);
        @(negedge clk) en8 = 1'b0;
        wait_q(1'b0, 24, 60, "b2b_wait");
        total++;
        if (q8.size() !== 24) $display("FAIL b2b_count got %0d exp 24", q8.size()); else pass_cnt++;
        check_frame8(0,  8'd0,  t0 + 2,  "b2b_f0");
        check_frame8(8,  8'd8,  t0 + 10, "b2b_f1");
        check_frame8(16, 8'd16, t0 + 18, "b2b_f2");
`ifdef SDF_REORDER_OVF_EN
        total++; if (ovf8 !== 1'b0) $display("FAIL b2b_overflow got %b exp 0", ovf8); else pass_cnt++;
`endif
    endtask

    task automatic test_gapped();
        int t;
        do_reset();
        drive8(8'd0, 8, 1'b1, t);
        wait_q(1'b0, 8, 40, "gap_wait");
        total++;
        if (q8.size() !== 8) $display("FAIL gap_count got %0d exp 8", q8.size()); else pass_cnt++;
        check_frame8(0, 8'd0, t + 2, "gap");
    endtask

    task automatic test_reset_midframe();
        int t;
        do_reset();
        drive8(8'd100, 5, 1'b0, t);
        do_reset();
        drive8(8'd40, 8, 1'b0, t);
        @(negedge clk) en8 = 1'b0;
        wait_q(1'b0, 8, 40, "midrst_wait");
        total++;
        if (q8.size() !== 8) $display("FAIL midrst_count got %0d exp 8", q8.size()); else pass_cnt++;
        check_frame8(0, 8'd40, t + 2, "midrst");
    endtask

    task automatic test_random64();
        int t_first = 0;
        int idx;
        smp_t s;
        for (int i = 0; i < 640; i++) begin
            dr[i] = W'($urandom_range(0, 255));
            di[i] = W'($urandom_range(0, 255));
        end
        dr[0]   = 8'h80; di[0]   = 8'h7F;
        dr[65]  = 8'h7F; di[65]  = 8'h80;
        dr[639] = 8'h80; di[639] = 8'h80;
        do_reset();
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            en64 = 1'b1;
            re64 = dr[i];
            im64 = di[i];
            if (i == 63) begin
                @(posedge clk);
                #1 t_first = cyc;
            end
        end
        @(negedge clk) en64 = 1'b0;
        wait_q(1'b1, 640, 900, "rand64_wait");
        for (int f = 0; f < 10; f++) begin
            for (int j = 0; j < 64; j++) begin
                idx = f * 64 + int'(ref_bitrev6(6'(j)));
                total++;
                if (f * 64 + j >= q64.size()) begin
                    $display("FAIL rand64[%0d] missing sample", f * 64 + j);
                end else begin
                    s = q64[f*64+j];
                    if (s.c !== t_first + 2 + f * 64 + j || s.re !== dr[idx] ||
                        s.im !== di[idx] || s.last !== (j == 63))
                        $display("FAIL rand64[%0d] got cyc=%0d re=%h im=%h last=%b exp cyc=%0d re=%h im=%h last=%b",
                                 f * 64 + j, s.c, s.re, s.im, s.last,
                                 t_first + 2 + f * 64 + j, dr[idx], di[idx], (j == 63));
                    else
                        pass_cnt++;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gapped();
        test_reset_midframe();
        test_random64();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/sdf_bitrev_reorder.md
Name: sdf_bitrev_reorder

Overview:
- Output-side companion of the radix-2^2 SDF FFT pipeline. It consumes the bit-reversed sample stream from the last sdf stage and re-emits each N-point frame in natural order.
- Ping-pong buffer of two N-entry banks. A frame is written at bit-reversed addresses and read back sequentially while the next frame fills the other bank.
- Uses the same enable/re/im streaming interface as the FFT stages, so it chains directly after the final stage.

Parameters:
- N, 64, FFT length; power of two, N >= 4; LOGN = $clog2(N).
- WIDTH, 8, bit width of each real/imag sample.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- enable_in  input  1  qualifies in_re/in_im; may be gapped.
- in_re  input  WIDTH  real part, bit-reversed order.
- in_im  input  WIDTH  imaginary part, bit-reversed order.
- enable_out  output  1  qualifies out_re/out_im.
- out_re  output  WIDTH  real part, natural order.
- out_im  output  WIDTH  imaginary part, natural order.
- frame_last  output  1  high with the final (index N-1) output sample of a frame.

Behaviour:
- One clock domain. Reset is synchronous and active-high, applied on the clk edge.
- Reset values:
  - enable_out=0, frame_last=0, out_re=0, out_im=0.
  - Write counter wcnt=0, wbank=0, rbank=0, rcnt=0.
  - full[1:0]=0; read FSM in IDLE.
  - RAM contents are not reset.
- Write side, on each edge with enable_in=1:
  - Store {in_re,in_im} at bank wbank, address bitrev(wcnt), where bitrev reverses all LOGN bits.
  - wcnt increments.
  - When wcnt==N-1: set full[wbank], toggle wbank, wrap wcnt to 0.
- With enable_in=0, the write side holds state.
- Read FSM states:
  - IDLE: when full[rbank]=1, go to READ with rcnt=0.
  - READ: issue a synchronous RAM read at (rbank, rcnt) every cycle; rcnt increments.
  - At rcnt==N-1: clear full[rbank], toggle rbank.
  - After that last read, if full of the new rbank is already set (including set on the same edge), stay in READ with rcnt=0, giving a gapless back-to-back frame. Otherwise go to IDLE.
- Output registers: one cycle after each read issue, out_re/out_im take the RAM data and enable_out=1. frame_last=1 for the read issued at rcnt==N-1.
- When no read is issued, enable_out=0 and frame_last=0. out_re/out_im hold their last values.
- Latency: if the final input sample of a frame is sampled at edge t and the reader is IDLE:
  - sample 0 of that frame appears with enable_out=1 after edge t+2;
  - the frame then streams on N consecutive cycles.
- Throughput: sustains continuous input (enable_in held high) indefinitely; output is continuous after the 2-cycle fill latency.
- Simultaneous events:
  - A write completion and a read completion on the same edge act on different banks and both take effect.
  - full set and full clear on the same bank cannot coincide under legal input.
- Overflow: enable_in=1 while full[wbank]=1 is illegal. Handling is defined under Optional Feature.
- Reset mid-frame: a partial input frame and any in-progress output frame are discarded. The first enable_in after reset is sample 0 of a new frame.

Optional Feature:
- Macro: SDF_REORDER_OVF_EN.
- Defined:
  - Adds output port overflow (1 bit), cleared only by rst.
  - A write attempted while full[wbank]=1 is dropped: no RAM write, wcnt unchanged.
  - overflow sets on the edge after the dropped write and stays sticky.
- Undefined:
  - No overflow port and no check.
  - The write proceeds and overwrites the bank; output content for that frame is unspecified, but FSM and counters stay consistent.

Test Plan:
- N=8, one frame, continuous enable_in, in_re=0..7, in_im=-(0..7): out_re=0,4,2,6,1,5,3,7 with matching in_im; enable_out high 8 cycles starting 2 edges after the last input; frame_last on the 8th output.
- N=8, three frames back-to-back, continuous input, ramps offset by 8 per frame: enable_out continuous for 24 cycles with no gap; per-frame bit-reversed ordering correct; frame_last on outputs 8, 16, 24.
- N=8, enable_in toggling 1-0 (50% duty): output frame identical to the continuous case; output starts 2 edges after the 8th accepted sample; output burst is gapless.
- N=64, WIDTH=8, random data across 10 frames: output matches a reference model bit-reversal permutation exactly, including extreme values 8'h80 and 8'h7F.
- rst asserted after 5 of 8 samples, then a fresh full frame sent: enable_out stays 0 until the new frame completes; output contains only the new frame's data.
- With SDF_REORDER_OVF_EN, N=8: hold the reader's work via a forced illegal burst of 17+ writes within one read window; overflow=1 on the edge after the first dropped write; earlier frames emerge uncorrupted; overflow clears only on rst.
